// File: rtl/sequenciador_contador.sv
// rtl/sequenciador_contador.sv - sweep controller for an external up/down counter
// Drives clear/enable/direction of a contador16-style counter through N programmed 0->limit->0 sweeps.
`timescale 1ns/1ps

module sequenciador_contador #(
   parameter int WIDTH        = 4,
   parameter int PAUSE_CYCLES = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_limite,
   input  logic [1:0]       i_n_varreduras,
   input  logic [WIDTH-1:0] i_contagem_in,
   output logic             o_cnt_clear_n,
   output logic             o_cnt_enable,
   output logic             o_cnt_dir,
   output logic             o_busy,
   output logic             o_done,
   output logic [2:0]       o_estado
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_UP    = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DOWN  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [3:0] PC_LOAD = 4'(PAUSE_CYCLES - 1);

   logic [2:0]       r_estado;
   logic [WIDTH-1:0] r_lim_q;
   logic [1:0]       r_rem_q;
   logic [3:0]       r_pc_q;

   logic [2:0]       w_estado_nxt;
   logic [WIDTH-1:0] w_lim_nxt;
   logic [1:0]       w_rem_nxt;
   logic [3:0]       w_pc_nxt;
   logic             w_at_lim;
   logic             w_at_zero;

   // Stop decisions use the live counter value so the count halts exactly on the bound.
   assign w_at_lim  = (i_contagem_in == r_lim_q);
   assign w_at_zero = (i_contagem_in == '0);

   always_comb begin
      w_estado_nxt = r_estado;
      w_lim_nxt    = r_lim_q;
      w_rem_nxt    = r_rem_q;
      w_pc_nxt     = r_pc_q;
      if (i_abort) begin
         w_estado_nxt = S_IDLE;
      end else begin
         case (r_estado)
            S_IDLE: begin
               if (i_start) begin
                  w_lim_nxt    = i_limite;
                  w_rem_nxt    = i_n_varreduras;
                  w_estado_nxt = S_CLEAR;
               end
            end
            S_CLEAR: w_estado_nxt = S_UP;
            S_UP: begin
               if (w_at_lim) begin
                  w_pc_nxt     = PC_LOAD;
                  w_estado_nxt = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (r_pc_q == 4'd0) begin
                  w_estado_nxt = S_DOWN;
               end else begin
                  w_pc_nxt = r_pc_q - 4'd1;
               end
            end
            S_DOWN: begin
               if (w_at_zero) begin
                  if (r_rem_q == 2'd0) begin
                     w_estado_nxt = S_DONE;
                  end else begin
                     w_rem_nxt    = r_rem_q - 2'd1;
                     w_estado_nxt = S_UP;
                  end
               end
            end
            S_DONE:  w_estado_nxt = S_IDLE;
            default: w_estado_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_estado <= S_IDLE;
         r_lim_q  <= '0;
         r_rem_q  <= '0;
         r_pc_q   <= '0;
      end else begin
         r_estado <= w_estado_nxt;
         r_lim_q  <= w_lim_nxt;
         r_rem_q  <= w_rem_nxt;
         r_pc_q   <= w_pc_nxt;
      end
   end

   assign o_estado      = r_estado;
   assign o_cnt_clear_n = (r_estado != S_CLEAR);
   assign o_cnt_enable  = ((r_estado == S_UP) && !w_at_lim) || ((r_estado == S_DOWN) && !w_at_zero);
   assign o_cnt_dir     = (r_estado == S_DOWN);
   assign o_busy        = (r_estado != S_IDLE);
   assign o_done        = (r_estado == S_DONE);

endmodule

// File: tb/tb_sequenciador_contador.sv
// tb/tb_sequenciador_contador.sv - self-checking bench for sequenciador_contador
`timescale 1ns/1ps

module tb_sequenciador_contador;

   localparam int W = 4;
   localparam int P = 3;
   localparam logic [2:0] E_IDLE  = 3'd0;
   localparam logic [2:0] E_CLR   = 3'd1;
   localparam logic [2:0] E_UP    = 3'd2;
   localparam logic [2:0] E_PAUSE = 3'd3;
   localparam logic [2:0] E_DOWN  = 3'd4;
   localparam logic [2:0] E_DONE  = 3'd5;

   typedef struct { logic [2:0] st; logic [W-1:0] cnt; } ent_t;
   typedef struct { int lim; int nv; int total; } vec_t;

   logic         clk = 1'b0;
   logic         reset, start, abort;
   logic [W-1:0] limite;
   logic [1:0]   nv;
   logic [W-1:0] r_cnt;
   logic         clr_n, en, dir, busy, done;
   logic [2:0]   estado;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   sequenciador_contador #(.WIDTH(W), .PAUSE_CYCLES(P)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_start        (start),
      .i_abort        (abort),
      .i_limite       (limite),
      .i_n_varreduras (nv),
      .i_contagem_in  (r_cnt),
      .o_cnt_clear_n  (clr_n),
      .o_cnt_enable   (en),
      .o_cnt_dir      (dir),
      .o_busy         (busy),
      .o_done         (done),
      .o_estado       (estado)
   );

   // Behavioural contador16: synchronous clear, enable, up/down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_cnt <= '0;
      else if (!clr_n) r_cnt <= '0;
      else if (en)     r_cnt <= dir ? r_cnt - 1'b1 : r_cnt + 1'b1;
   end

   always @(negedge clk) if (done === 1'b1) n_done++;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, a, e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {estado, clr_n, en, dir, busy, done};
   endfunction

   function automatic logic [7:0] exp_outs(input logic [2:0] st, input logic [W-1:0] c, input int L);
      logic e;
      e = ((st == E_UP) && (c != W'(L))) || ((st == E_DOWN) && (c != '0));
      return {st, st != E_CLR, e, st == E_DOWN, st != E_IDLE, st == E_DONE};
   endfunction

   task automatic run_sweep(input int L, input int N, input logic [W-1:0] prev, input bit noise, input int total);
      ent_t q[$];
      int   busy_cyc;
      int   d0;
      busy_cyc = 0;
      d0 = n_done;
      q.push_back('{st: E_CLR, cnt: prev});
      for (int s = 0; s <= N; s++) begin
         for (int v = 0; v <= L; v++)  q.push_back('{st: E_UP, cnt: W'(v)});
         for (int k = 0; k < P; k++)   q.push_back('{st: E_PAUSE, cnt: W'(L)});
         for (int v = L; v >= 0; v--)  q.push_back('{st: E_DOWN, cnt: W'(v)});
      end
      q.push_back('{st: E_DONE, cnt: '0});
      start = 1'b1; limite = W'(L); nv = 2'(N);
      @(negedge clk);
      chk("accept_idle", 32'(outs()), 32'(exp_outs(E_IDLE, '0, L)));
      step();
      foreach (q[i]) begin
         start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (noise) begin
            limite = W'($urandom);
            nv     = 2'($urandom);
         end
         @(negedge clk);
         if (busy) busy_cyc++;
         chk($sformatf("trace[%0d] L=%0d N=%0d", i, L, N), 32'({outs(), r_cnt}),
             32'({exp_outs(q[i].st, q[i].cnt, L), q[i].cnt}));
         step();
      end
      start = 1'b0;
      @(negedge clk);
      chk("end_idle", 32'({outs(), r_cnt}), 32'({exp_outs(E_IDLE, '0, L), 4'd0}));
      chk($sformatf("busy_cycles L=%0d N=%0d", L, N), busy_cyc, total);
      chk("done_pulses", n_done - d0, 1);
      step();
   endtask

   initial begin
      vec_t tbl[4];
      bit   found;
      int   d0, L, N;
      tbl[0] = '{lim: 5,  nv: 0, total: 17};
      tbl[1] = '{lim: 15, nv: 1, total: 72};
      tbl[2] = '{lim: 0,  nv: 0, total: 7};
      tbl[3] = '{lim: 3,  nv: 3, total: 46};

      reset = 1'b1; start = 1'b0; abort = 1'b0; limite = '0; nv = '0;
      #3;
      chk("reset_hold", 32'(outs()), 32'(exp_outs(E_IDLE, '0, 0)));
      #19 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_reset", 32'(outs()), 32'(exp_outs(E_IDLE, '0, 0)));
      end
      step();

      foreach (tbl[i]) run_sweep(tbl[i].lim, tbl[i].nv, '0, 1'b0, tbl[i].total);

      // Abort mid-UP, then start+abort together, then relaunch.
      d0 = n_done;
      start = 1'b1; limite = 4'd5; nv = 2'd0;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (estado == E_UP && r_cnt == 4'd3) found = 1'b1;
         else step();
      end
      chk("abort_reach", 32'(found), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(outs()), 32'(exp_outs(E_IDLE, '0, 0)));
      chk("abort_cnt_left", 32'(r_cnt), 32'd4);
      step();
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_same", 32'(outs()), 32'(exp_outs(E_IDLE, '0, 0)));
      chk("abort_no_done", n_done - d0, 0);
      step();
      run_sweep(5, 0, 4'd4, 1'b0, 17);

      for (int r = 0; r < 8; r++) begin
         L = $urandom_range(0, 15);
         N = $urandom_range(0, 3);
         run_sweep(L, N, '0, 1'b1, 2 + (N + 1) * (2 * L + 2 + P));
      end

      // Re-start during PAUSE with a different limit, then async reset mid-DOWN.
      start = 1'b1; limite = 4'd5; nv = 2'd0;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (estado == E_PAUSE) found = 1'b1;
         else step();
      end
      chk("pause_reach", 32'(found), 32'd1);
      start = 1'b1; limite = 4'd9; nv = 2'd3;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (estado == E_DOWN) found = 1'b1;
         else step();
      end
      chk("down_reach", 32'(found), 32'd1);
      chk("lim_kept", 32'(r_cnt), 32'd5);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (estado == E_DOWN && r_cnt == 4'd3) found = 1'b1;
         else begin
            step();
            @(negedge clk);
         end
      end
      chk("down3_reach", 32'(found), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset", 32'(outs()), 32'(exp_outs(E_IDLE, '0, 0)));
      #10 reset = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sequenciador_contador.md
Name: sequenciador_contador

Overview:
Controller that sequences an external up/down counter of the contador16 type (clear, enable, direction) through programmed sweeps. Each sweep counts up from 0 to a latched limit, holds for a fixed pause, then counts back down to 0. The block sits between a command source (start/abort) and the counter instance. It reads the counter value back so it stops exactly on the limit and never overshoots.

Parameters:
WIDTH, 4, counter width; sets the width of limite and contagem_in.
PAUSE_CYCLES, 3, number of cycles held at the top of each sweep (allowed range 1..15).

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  command pulse; sampled only in IDLE.
abort  in  1  return to IDLE on the next edge; highest priority after reset.
limite  in  WIDTH  top value of each sweep; latched when start is accepted.
n_varreduras  in  2  number of sweeps minus 1 (0 gives 1 sweep, 3 gives 4 sweeps); latched when start is accepted.
contagem_in  in  WIDTH  current counter output, fed back from the counter.
cnt_clear_n  out  1  active-low clear to the counter.
cnt_enable  out  1  counter enable.
cnt_dir  out  1  counter direction: 0 = up, 1 = down.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when all sweeps complete.
estado  out  3  state code: IDLE=0, CLEAR=1, UP=2, PAUSE=3, DOWN=4, DONE=5.

Behaviour:
- Reset values while reset is high (asynchronous): state IDLE, cnt_clear_n=1, cnt_enable=0, cnt_dir=0, busy=0, done=0, all internal registers 0. Reset asserted mid-sweep forces these values immediately.
- Outputs are decoded from the state register plus contagem_in, with no extra register stage:
  - cnt_clear_n = 0 only in CLEAR.
  - cnt_enable = (UP and contagem_in != lim_q) or (DOWN and contagem_in != 0).
  - cnt_dir = 1 only in DOWN; 0 in all other states.
  - done = 1 only in DONE.
- IDLE: when start=1 and abort=0, latch lim_q=limite and sweep counter rem_q=n_varreduras, then go to CLEAR. Otherwise stay.
- CLEAR: exactly 1 cycle, then UP. The counter reads 0 from the following cycle.
- UP: when contagem_in == lim_q, go to PAUSE and load pause counter pc_q=PAUSE_CYCLES-1. Enable is already low in that cycle, so the count stops exactly at lim_q.
- PAUSE: hold with enable low. When pc_q==0 go to DOWN; otherwise decrement pc_q. Total time in PAUSE is PAUSE_CYCLES cycles.
- DOWN: when contagem_in == 0: if rem_q==0 go to DONE, otherwise decrement rem_q and go to UP.
- DONE: 1 cycle, then IDLE.
- Timing per run: UP and DOWN each occupy lim_q+1 cycles. One sweep with lim_q=L from CLEAR entry to DONE exit is 1 + (L+1) + P + (L+1) + 1 cycles.
- lim_q=0: UP and DOWN each last 1 cycle, enable never asserts, and the pause still runs.
- start while busy: ignored; latched values do not change.
- limite/n_varreduras changing mid-run: no effect.
- abort while busy: next state is IDLE, no done pulse, enable low from the next cycle on, counter value left as is.
- abort and start in the same IDLE cycle: stay in IDLE.
- Wrap-around: the counter never wraps under this controller. UP stops at lim_q ≤ 2^WIDTH-1 and DOWN stops at 0.
- Counter value out of range (contagem_in > lim_q in UP, e.g. a corrupted counter): the state machine stays in UP with enable high. The counter then wraps and reaches lim_q, so the controller recovers without a deadlock.

Test Plan:
1. Reset held 20 ns, then released: estado=0, busy=0, done=0, cnt_clear_n=1, cnt_enable=0 throughout.
2. limite=5, n_varreduras=0, start pulse: one CLEAR cycle with cnt_clear_n=0. Count runs 0,1,2,3,4,5 with dir=0, holds at 5 for 3 cycles, runs 5,4,3,2,1,0 with dir=1. done pulses 17 cycles after CLEAR entry, then busy=0.
3. limite=F, n_varreduras=1: two full sweeps 0→F→0. Count never shows a wrap (F→0 up or 0→F down). Exactly one done pulse.
4. limite=0, n_varreduras=0: cnt_enable is never 1. State sequence CLEAR, UP, PAUSE×3, DOWN, DONE, IDLE.
5. Abort asserted while count=3 in UP: the next state is IDLE and cnt_enable=0. No done pulse. A start pulse 2 cycles later relaunches from CLEAR.
6. Start re-pulsed during PAUSE with limite=9 on the bus: ignored, the sweep keeps lim_q=5. Reset asserted mid-DOWN: outputs go to reset values without waiting for a clock edge.
